// File: rtl/state_setting_if.sv
// state_setting_if: state/button inputs and value/display outputs of the time-entry state
interface state_setting_if;
  logic [2:0] currentState;
  logic btnNext;
  logic btnInc;
  logic btnDec;
  logic btnOk;
  logic [15:0] valueOut;
  logic [15:0] digitsOut;
  logic [1:0] cursor;
  logic finished;
  modport master (
    output currentState, btnNext, btnInc, btnDec, btnOk,
    input  valueOut, digitsOut, cursor, finished
  );
  modport slave (
    input  currentState, btnNext, btnInc, btnDec, btnOk,
    output valueOut, digitsOut, cursor, finished
  );
endinterface

// File: rtl/state_setting.sv
// state_setting: digit-by-digit BCD mm:ss entry with blinking cursor and confirm pulse
module state_setting #(
  parameter logic [2:0]  stateID       = 3'd1,
  parameter logic [15:0] DEFAULT_VALUE = 16'h0500,
  parameter int          BLINK_DIV     = 25_000_000
) (
  input logic clk,
  input logic reset,
  state_setting_if.slave bus
);
  logic [3:0] btn, s1_q, s2_q, s3_q, ev;
  logic active, active_q, entry, act_ok, act_next, act_inc, act_dec, acted, wrap;
  logic [1:0] cur, cursor_q, cursor_d;
  logic [3:0] sh, dig, max, dig_inc, dig_dec, new_dig;
  logic [15:0] value_q, value_d, digits_q, digits_d;
  logic fin_q, fin_d, phase_q, phase_d;
  logic [25:0] cnt_q, cnt_d;
  assign btn = {bus.btnOk, bus.btnNext, bus.btnInc, bus.btnDec};
  assign bus.valueOut = value_q;
  assign bus.digitsOut = digits_q;
  assign bus.cursor = cursor_q;
  assign bus.finished = fin_q;
  // Edit decode: one prioritised event per cycle applied to the selected digit, plus blink timing
  always_comb begin
    active = bus.currentState == stateID;
    entry = active & ~active_q;
    ev = s2_q & ~s3_q;
    cur = entry ? 2'd0 : cursor_q;
    act_ok = active & ev[3] & (value_q != 16'h0000);
    act_next = active & ~ev[3] & ev[2];
    act_inc = active & ~|ev[3:2] & ev[1];
    act_dec = active & ~|ev[3:1] & ev[0];
    acted = act_ok | act_next | act_inc | act_dec;
    sh = {~cur, 2'b00};
    dig = 4'(value_q >> sh);
    max = cur == 2'd2 ? 4'd5 : 4'd9;
    dig_inc = dig >= max ? 4'd0 : dig + 4'd1;
    dig_dec = dig == 4'd0 ? max : dig > max ? max - 4'd1 : dig - 4'd1;
    new_dig = act_inc ? dig_inc : dig_dec;
    value_d = (act_inc | act_dec) ? ((value_q & ~(16'hF << sh)) | (16'(new_dig) << sh)) : value_q;
    cursor_d = act_next ? cur + 2'd1 : cur;
    fin_d = act_ok;
    wrap = cnt_q == 26'(BLINK_DIV - 1);
    cnt_d = (!active || entry || acted || wrap) ? 26'd0 : cnt_q + 26'd1;
    phase_d = (!active || entry || acted) ? 1'b0 : phase_q ^ wrap;
    digits_d = phase_d ? value_d | (16'hF << {~cursor_d, 2'b00}) : value_d;
  end
  // Registered state: synchronizers, edit value, cursor, blink and display
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      active_q <= 1'b0;
      value_q <= DEFAULT_VALUE;
      digits_q <= DEFAULT_VALUE;
      cursor_q <= 2'd0;
      fin_q <= 1'b0;
      phase_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      s3_q <= s2_q;
      active_q <= active;
      value_q <= value_d;
      digits_q <= digits_d;
      cursor_q <= cursor_d;
      fin_q <= fin_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
